// File: rtl/fcims_pkg.sv
// fcims_pkg: shared definitions for the FCIMS checkout controller.
//   state_t     - controller states (IDLE, COLLECT, DISPENSE, CHANGE)
//   COIN_*      - 2-bit coin codes shared by coin_code and chg_code
//   coin_value  - maps a coin code to its face value (1, 2, 5 or 10)
package fcims_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    DISPENSE = 2'd2,
    CHANGE   = 2'd3
  } state_t;

  localparam logic [1:0] COIN_1  = 2'b00;
  localparam logic [1:0] COIN_2  = 2'b01;
  localparam logic [1:0] COIN_5  = 2'b10;
  localparam logic [1:0] COIN_10 = 2'b11;

  function automatic logic [3:0] coin_value(input logic [1:0] code);
    logic [3:0] v;
    case (code)
      COIN_1:  v = 4'd1;
      COIN_2:  v = 4'd2;
      COIN_5:  v = 4'd5;
      default: v = 4'd10;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/fcims_change_sel.sv
// fcims_change_sel: combinational greedy change-coin selector.
// Picks the largest coin not exceeding the remaining change (10, 5, 2, 1).
// Ports:
//   remaining in  PRICE_W  change still owed
//   code      out 2        coin code to issue (COIN_1 when nothing is owed)
//   value     out 4        face value of that coin, 0 when nothing is owed
module fcims_change_sel
  import fcims_pkg::*;
#(
  parameter int PRICE_W = 8
) (
  input  logic [PRICE_W-1:0] remaining,
  output logic [1:0]         code,
  output logic [3:0]         value
);

  always_comb begin
    code  = COIN_1;
    value = 4'd0;
    if (remaining >= PRICE_W'(10)) begin
      code = COIN_10;
    end else if (remaining >= PRICE_W'(5)) begin
      code = COIN_5;
    end else if (remaining >= PRICE_W'(2)) begin
      code = COIN_2;
    end
    if (remaining != '0) begin
      value = coin_value(code);
    end
  end

endmodule

// File: rtl/fcims_checkout.sv
// fcims_checkout: payment and checkout controller fed by the FCIMS price stage.
// Accepts a price, collects coins until it is covered, strobes dispense for one
// cycle, then pays change one coin per cycle, largest coin first. Cancel in
// COLLECT refunds everything collected so far without dispensing.
//
// Optional feature (macro FCIMS_TIMEOUT_EN): an idle counter in COLLECT, cleared
// by every coin; after TIMEOUT_CYCLES coin-free cycles the purchase is cancelled.
// Without the macro there is no counter and COLLECT waits indefinitely.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous, active-low reset
//   price_valid  in   price offer, taken only while ready=1
//   price        in   amount due
//   coin_valid   in   one coin inserted this cycle
//   coin_code    in   coin value code (00=1, 01=2, 10=5, 11=10)
//   cancel       in   abort purchase, honoured only in COLLECT
//   ready        out  high in IDLE
//   coin_reject  out  pulse one cycle after a coin arrives outside COLLECT
//   dispense     out  one-cycle goods-release strobe
//   chg_valid    out  one change coin issued this cycle
//   chg_code     out  change coin code
//   paid         out  running coin total
//   due          out  latched price
module fcims_checkout
  import fcims_pkg::*;
#(
  parameter int PRICE_W = 8
`ifdef FCIMS_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               price_valid,
  input  logic [PRICE_W-1:0] price,
  input  logic               coin_valid,
  input  logic [1:0]         coin_code,
  input  logic               cancel,
  output logic               ready,
  output logic               coin_reject,
  output logic               dispense,
  output logic               chg_valid,
  output logic [1:0]         chg_code,
  output logic [PRICE_W-1:0] paid,
  output logic [PRICE_W-1:0] due
);

  state_t             state_reg, state_next;
  logic [PRICE_W-1:0] paid_reg, paid_next;
  logic [PRICE_W-1:0] due_reg, due_next;
  logic [PRICE_W-1:0] rem_reg, rem_next;
  logic               ready_reg, ready_next;
  logic               reject_reg, reject_next;
  logic               dispense_reg, dispense_next;
  logic               chg_valid_reg, chg_valid_next;
  logic [1:0]         chg_code_reg, chg_code_next;

  logic [PRICE_W-1:0] coin_amt;
  logic [PRICE_W-1:0] paid_sum;
  logic [1:0]         sel_code;
  logic [3:0]         sel_value;
  logic               timeout;

  assign coin_amt = coin_valid ? PRICE_W'(coin_value(coin_code)) : '0;
  // The coin arriving this cycle is counted before cancel/cover decisions.
  assign paid_sum = paid_reg + coin_amt;

  fcims_change_sel #(
    .PRICE_W(PRICE_W)
  ) u_change_sel (
    .remaining(rem_reg),
    .code     (sel_code),
    .value    (sel_value)
  );

`ifdef FCIMS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt_reg, idle_cnt_next;

  // Fires on the coin-free cycle that brings the count up to TIMEOUT_CYCLES.
  assign timeout = (state_reg == COLLECT) && !coin_valid &&
                   (idle_cnt_reg == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    idle_cnt_next = '0;
    if (state_reg == COLLECT && !coin_valid) begin
      idle_cnt_next = idle_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      idle_cnt_reg <= '0;
    end else begin
      idle_cnt_reg <= idle_cnt_next;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_next     = state_reg;
    paid_next      = paid_reg;
    due_next       = due_reg;
    rem_next       = rem_reg;
    dispense_next  = 1'b0;
    chg_valid_next = 1'b0;
    chg_code_next  = COIN_1;
    reject_next    = coin_valid && (state_reg != COLLECT);

    case (state_reg)
      IDLE: begin
        if (price_valid) begin
          due_next   = price;
          paid_next  = '0;
          state_next = (price == '0) ? DISPENSE : COLLECT;
        end
      end
      COLLECT: begin
        paid_next = paid_sum;
        if (cancel || timeout) begin
          // Cancel beats a covering coin in the same cycle: full refund.
          rem_next   = paid_sum;
          state_next = (paid_sum != '0) ? CHANGE : IDLE;
        end else if (paid_sum >= due_reg) begin
          state_next = DISPENSE;
        end
      end
      DISPENSE: begin
        dispense_next = 1'b1;
        rem_next      = paid_reg - due_reg;
        state_next    = (paid_reg != due_reg) ? CHANGE : IDLE;
      end
      CHANGE: begin
        chg_valid_next = 1'b1;
        chg_code_next  = sel_code;
        rem_next       = rem_reg - PRICE_W'(sel_value);
        if (rem_reg == PRICE_W'(sel_value)) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // ready follows the state register so the handshake never lags it.
    ready_next = (state_next == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= IDLE;
      paid_reg      <= '0;
      due_reg       <= '0;
      rem_reg       <= '0;
      ready_reg     <= 1'b1;
      reject_reg    <= 1'b0;
      dispense_reg  <= 1'b0;
      chg_valid_reg <= 1'b0;
      chg_code_reg  <= COIN_1;
    end else begin
      state_reg     <= state_next;
      paid_reg      <= paid_next;
      due_reg       <= due_next;
      rem_reg       <= rem_next;
      ready_reg     <= ready_next;
      reject_reg    <= reject_next;
      dispense_reg  <= dispense_next;
      chg_valid_reg <= chg_valid_next;
      chg_code_reg  <= chg_code_next;
    end
  end

  assign ready       = ready_reg;
  assign coin_reject = reject_reg;
  assign dispense    = dispense_reg;
  assign chg_valid   = chg_valid_reg;
  assign chg_code    = chg_code_reg;
  assign paid        = paid_reg;
  assign due         = due_reg;

endmodule

// File: tb/tb_fcims_checkout.sv
// tb_fcims_checkout: self-checking bench for fcims_checkout.
// A transaction-level model schedules the expected dispense and change coins
// on an absolute cycle timeline; every cycle the DUT outputs are compared
// against that timeline. Directed scenarios add literal expectations.
module tb_fcims_checkout;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       price_valid = 1'b0;
  logic [7:0] price = 8'd0;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_code = 2'b00;
  logic       cancel = 1'b0;
  logic       ready, coin_reject, dispense, chg_valid;
  logic [1:0] chg_code;
  logic [7:0] paid, due;

  always #5 clk = ~clk;

  fcims_checkout dut (
    .clk        (clk),
    .reset      (reset),
    .price_valid(price_valid),
    .price      (price),
    .coin_valid (coin_valid),
    .coin_code  (coin_code),
    .cancel     (cancel),
    .ready      (ready),
    .coin_reject(coin_reject),
    .dispense   (dispense),
    .chg_valid  (chg_valid),
    .chg_code   (chg_code),
    .paid       (paid),
    .due        (due)
  );

  int total = 0;
  int bad = 0;

  // Model: 0 = idle, 1 = collecting, 2 = busy until m_ready_cyc.
  int cyc = 0;
  int m_state = 0;
  int m_due = 0;
  int m_paid = 0;
  int m_disp_cyc = -1;
  int m_chg_start = -1;
  int m_ready_cyc = 0;
  int m_chg_q[$];
  bit m_rej = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  function automatic int cval(input logic [1:0] c);
    case (c)
      2'd0: return 1;
      2'd1: return 2;
      2'd2: return 5;
      default: return 10;
    endcase
  endfunction

  // Ends the purchase at the current edge: with goods (dispense next cycle,
  // change after that) or as a refund (change starting next cycle).
  task automatic finish(input bit with_goods);
    int r;
    m_state = 2;
    m_chg_q.delete();
    if (with_goods) begin
      m_disp_cyc  = cyc + 1;
      r           = m_paid - m_due;
      m_chg_start = cyc + 2;
    end else begin
      r           = m_paid;
      m_chg_start = cyc + 1;
    end
    while (r > 0) begin
      if (r >= 10) begin m_chg_q.push_back(3); r -= 10; end
      else if (r >= 5) begin m_chg_q.push_back(2); r -= 5; end
      else if (r >= 2) begin m_chg_q.push_back(1); r -= 2; end
      else begin m_chg_q.push_back(0); r -= 1; end
    end
    m_ready_cyc = m_chg_start - 1 + m_chg_q.size();
    $display("txn cyc=%0d due=%0d paid=%0d %s change_coins=%0d",
             cyc, m_due, m_paid, with_goods ? "dispense" : "refund", m_chg_q.size());
  endtask

  task automatic model_edge();
    cyc++;
    if (!reset) begin
      m_state = 0; m_due = 0; m_paid = 0; m_disp_cyc = -1;
      m_chg_start = -1; m_chg_q.delete(); m_rej = 1'b0;
      return;
    end
    m_rej = coin_valid && (m_state != 1);
    case (m_state)
      0: if (price_valid) begin
        m_due = price;
        m_paid = 0;
        if (price == 8'd0) finish(1'b1);
        else m_state = 1;
      end
      1: begin
        if (coin_valid) m_paid += cval(coin_code);
        if (cancel) finish(1'b0);
        else if (m_paid >= m_due) finish(1'b1);
      end
      default: ;
    endcase
    if (m_state == 2 && cyc >= m_ready_cyc) m_state = 0;
  endtask

  task automatic compare_all();
    bit cv;
    int code;
    cv = (m_chg_start >= 0) && (cyc >= m_chg_start) && (cyc < m_chg_start + m_chg_q.size());
    code = cv ? m_chg_q[cyc - m_chg_start] : 0;
    check("ready", 32'(ready), 32'(m_state == 0));
    check("dispense", 32'(dispense), 32'(cyc == m_disp_cyc));
    check("chg_valid", 32'(chg_valid), 32'(cv));
    check("chg_code", 32'(chg_code), 32'(code));
    check("coin_reject", 32'(coin_reject), 32'(m_rej));
    check("paid", 32'(paid), 32'(m_paid));
    check("due", 32'(due), 32'(m_due));
  endtask

  task automatic step(input logic rst_n, input logic pv, input logic [7:0] pr,
                      input logic cv, input logic [1:0] cc, input logic cn);
    @(negedge clk);
    reset = rst_n; price_valid = pv; price = pr;
    coin_valid = cv; coin_code = cc; cancel = cn;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle_step();
    step(1'b1, 1'b0, 8'd0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic coin(input logic [1:0] cc, input logic cn);
    step(1'b1, 1'b0, 8'd0, 1'b1, cc, cn);
  endtask

  task automatic offer(input logic [7:0] pr);
    step(1'b1, 1'b1, pr, 1'b0, 2'd0, 1'b0);
  endtask

  initial begin
    // Reset state
    step(1'b0, 1'b0, 8'd0, 1'b0, 2'd0, 1'b0);
    step(1'b0, 1'b0, 8'd0, 1'b0, 2'd0, 1'b0);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_paid", 32'(paid), 32'd0);
    check("rst_due", 32'(due), 32'd0);
    check("rst_chg_valid", 32'(chg_valid), 32'd0);

    // Exact payment: 12 with 10 + 2
    idle_step();
    offer(8'd12);
    coin(2'd3, 1'b0);
    coin(2'd1, 1'b0);
    idle_step();
    check("exact_dispense", 32'(dispense), 32'd1);
    check("exact_paid", 32'(paid), 32'd12);
    check("exact_no_chg", 32'(chg_valid), 32'd0);
    check("exact_ready", 32'(ready), 32'd1);

    // Overpayment: 12 with 10 + 5, change 2 then 1
    offer(8'd12);
    coin(2'd3, 1'b0);
    coin(2'd2, 1'b0);
    idle_step();
    check("over_dispense", 32'(dispense), 32'd1);
    idle_step();
    check("over_chg1_valid", 32'(chg_valid), 32'd1);
    check("over_chg1_code", 32'(chg_code), 32'd1);
    idle_step();
    check("over_chg2_code", 32'(chg_code), 32'd0);
    check("over_ready", 32'(ready), 32'd1);

    // Cancel with the 2-coin: refund 5 then 2, no dispense
    offer(8'd20);
    coin(2'd2, 1'b0);
    coin(2'd1, 1'b1);
    idle_step();
    check("cancel_no_disp", 32'(dispense), 32'd0);
    check("cancel_chg1_code", 32'(chg_code), 32'd2);
    idle_step();
    check("cancel_chg2_code", 32'(chg_code), 32'd1);
    check("cancel_ready", 32'(ready), 32'd1);

    // Zero price and coin rejection in IDLE
    offer(8'd0);
    idle_step();
    check("zero_dispense", 32'(dispense), 32'd1);
    check("zero_ready", 32'(ready), 32'd1);
    coin(2'd3, 1'b0);
    check("reject_pulse", 32'(coin_reject), 32'd1);
    check("reject_paid", 32'(paid), 32'd0);
    idle_step();
    check("reject_clear", 32'(coin_reject), 32'd0);

    // Reset during CHANGE with 8 outstanding
    offer(8'd12);
    coin(2'd3, 1'b0);
    coin(2'd3, 1'b0);
    idle_step();
    check("mid_dispense", 32'(dispense), 32'd1);
    step(1'b0, 1'b0, 8'd0, 1'b0, 2'd0, 1'b0);
    check("mid_ready", 32'(ready), 32'd1);
    check("mid_chg_valid", 32'(chg_valid), 32'd0);
    check("mid_paid", 32'(paid), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      logic       r_rst, r_pv, r_cv, r_cn;
      logic [7:0] r_pr;
      logic [1:0] r_cc;
      r_rst = ($urandom_range(0, 299) != 0);
      r_pv  = ($urandom_range(0, 3) == 0);
      r_pr  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 225)) : 8'($urandom_range(0, 30));
      r_cv  = ($urandom_range(0, 9) < 6);
      r_cc  = 2'($urandom_range(0, 3));
      r_cn  = ($urandom_range(0, 49) == 0);
      step(r_rst, r_pv, r_pr, r_cv, r_cc, r_cn);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
